// File: rtl/cpu_pkg.sv
// Shared fetch-stage types, widths and branch-offset helpers.
// Offsets are word counts sign-extended to a 64-bit byte offset.
package cpu_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 64;
   localparam int PC_INCR = 4;
   localparam int CNT_W   = 8;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      ERROR = 2'd2
   } fetch_state_t;

   function automatic logic [ADDR_W-1:0] b_off(input logic [25:0] imm);
      return {{36{imm[25]}}, imm, 2'b00};
   endfunction

   function automatic logic [ADDR_W-1:0] cbz_off(input logic [18:0] imm);
      return {{43{imm[18]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: sequential, unconditional (imm26) or compare-branch (imm19).
// All additions wrap modulo 2^64.
module pc_next_calc
   import cpu_pkg::*;
(
   input  logic [ADDR_W-1:0]  pc,
   input  logic [INSTR_W-1:0] instr,
   input  logic               br_taken,
   input  logic               uncond_br,
   output logic [ADDR_W-1:0]  next_pc
);

   logic [ADDR_W-1:0] off;
   logic              unused_opc;

   assign unused_opc = ^instr[31:26];

   always_comb begin
      off = ADDR_W'(PC_INCR);
      if (br_taken) begin
         if (uncond_br) off = b_off(instr[25:0]);
         else           off = cbz_off(instr[23:5]);
      end
      next_pc = pc + off;
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: request, hold for decode, redirect on branch.
// A fetch that waits TIMEOUT cycles without ack parks in ERROR until reset.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        br_taken,
   input  logic        uncond_br,
   output logic [63:0] pc,
   output logic        fetch_err
);

   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

   fetch_state_t       state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  next_pc;

   pc_next_calc u_pc_next (
      .pc        (pc_q),
      .instr     (instr_q),
      .br_taken  (br_taken),
      .uncond_br (uncond_br),
      .next_pc   (next_pc)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == TO_CNT) state_d = ERROR;
            end
         end
         HOLD: begin
            cnt_d = '0;
            // branch inputs only matter on the consuming cycle
            if (instr_ready) begin
               pc_d    = next_pc;
               state_d = FETCH;
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = FETCH;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   always_ff @(posedge clk) begin
      if (reset) instr_q <= '0;
      else       instr_q <= instr_d;
   end

   assign imem_req    = (state_q == FETCH) && !reset;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = (state_q == HOLD);
   assign fetch_err   = (state_q == ERROR);

endmodule

// File: tb/tb_instr_fetch.sv
// Random and directed bench for instr_fetch against a behavioural model.
// The model tracks what the fetch unit should expose after every edge.
module tb_instr_fetch;

   localparam int TO = 4;
   localparam logic [31:0] NOP = 32'hD503201F;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        br_taken;
   logic        uncond_br;
   logic [63:0] pc;
   logic        fetch_err;

   int checks = 0;
   int errors = 0;

   // model: 0 waiting for memory, 1 instruction held, 2 dead
   int               m_mode;
   longint unsigned  m_pc;
   logic [31:0]      m_instr;
   int               m_wait;

   instr_fetch #(
      .RESET_PC (64'h0),
      .TIMEOUT  (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .br_taken    (br_taken),
      .uncond_br   (uncond_br),
      .pc          (pc),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      int off;
      if (reset) begin
         m_mode = 0; m_pc = 0; m_instr = 0; m_wait = 0;
      end else if (m_mode == 0) begin
         if (imem_ack) begin
            m_instr = imem_rdata;
            m_mode  = 1;
         end else begin
            m_wait++;
            if (m_wait >= TO) m_mode = 2;
         end
      end else if (m_mode == 1 && instr_ready) begin
         if (!br_taken) begin
            off = 4;
         end else if (uncond_br) begin
            off = int'(m_instr[25:0]);
            if (off >= (1 << 25)) off -= (1 << 26);
            off *= 4;
         end else begin
            off = int'(m_instr[23:5]);
            if (off >= (1 << 18)) off -= (1 << 19);
            off *= 4;
         end
         m_pc   = m_pc + 64'(longint'(off));
         m_mode = 0;
         m_wait = 0;
      end
   endtask

   task automatic compare();
      check("req", 64'(imem_req), 64'(m_mode == 0 && !reset));
      check("addr", imem_addr, m_pc);
      check("pc", pc, m_pc);
      check("valid", 64'(instr_valid), 64'(m_mode == 1));
      check("instr", 64'(instr), 64'(m_instr));
      check("err", 64'(fetch_err), 64'(m_mode == 2));
   endtask

   task automatic cyc(input bit r, input bit a, input logic [31:0] d,
                      input bit rdy, input bit br, input bit unc);
      reset       = r;
      imem_ack    = a;
      imem_rdata  = d;
      instr_ready = rdy;
      br_taken    = br;
      uncond_br   = unc;
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic take(input logic [31:0] d, input bit br, input bit unc);
      cyc(0, 1, d, 0, 0, 0);
      cyc(0, 0, 32'h0, 1, br, unc);
   endtask

   initial begin
      reset = 1; imem_ack = 0; imem_rdata = 0;
      instr_ready = 0; br_taken = 0; uncond_br = 0;
      m_mode = 0; m_pc = 0; m_instr = 0; m_wait = 0;

      cyc(1, 1, 32'hDEADBEEF, 1, 1, 1);
      cyc(1, 1, 32'hDEADBEEF, 1, 1, 1);
      check("rst_instr", 64'(instr), 64'h0);
      check("rst_valid", 64'(instr_valid), 64'h0);
      check("rst_req", 64'(imem_req), 64'h0);

      cyc(0, 0, 32'h0, 0, 0, 0);
      check("first_addr", imem_addr, 64'h0);
      cyc(0, 0, 32'h0, 0, 0, 0);
      cyc(0, 1, 32'h91000421, 0, 0, 0);
      check("hold_valid", 64'(instr_valid), 64'h1);
      check("hold_instr", 64'(instr), 64'h91000421);
      cyc(0, 0, 32'h0, 1, 0, 0);
      check("seq_addr", imem_addr, 64'h4);

      for (int i = 0; i < 3; i++) take(NOP, 0, 0);
      take(32'h17FFFFFE, 1, 1);
      check("b_back", imem_addr, 64'h8);
      for (int i = 0; i < 6; i++) take(NOP, 0, 0);
      take(32'hB4000060, 1, 0);
      check("cbz_taken", imem_addr, 64'h2C);
      take(32'h17FFFFFD, 1, 1);
      check("b_back3", imem_addr, 64'h20);
      take(32'hB4000060, 0, 0);
      check("cbz_not", imem_addr, 64'h24);

      cyc(0, 1, 32'hAABBCCDD, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1'($urandom), $urandom, 0, 1'($urandom), 1'($urandom));
         check("bp_instr", 64'(instr), 64'hAABBCCDD);
         check("bp_pc", pc, 64'h24);
         check("bp_valid", 64'(instr_valid), 64'h1);
         check("bp_req", 64'(imem_req), 64'h0);
      end
      cyc(0, 0, 32'h0, 1, 0, 0);
      check("bp_release", imem_addr, 64'h28);

      cyc(1, 0, 32'h0, 0, 0, 0);
      take(32'h17FFFFFF, 1, 1);
      check("wrap_neg", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      take(NOP, 0, 0);
      check("wrap_zero", imem_addr, 64'h0);

      for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 0, 0, 0);
      check("to_pending", 64'(fetch_err), 64'h0);
      cyc(0, 0, 32'h0, 0, 0, 0);
      check("to_err", 64'(fetch_err), 64'h1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, $urandom, 1, 0, 0);
         check("err_req", 64'(imem_req), 64'h0);
         check("err_sticky", 64'(fetch_err), 64'h1);
      end
      cyc(1, 0, 32'h0, 0, 0, 0);
      check("err_clr", 64'(fetch_err), 64'h0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 0, 0, 0);
      cyc(0, 1, 32'h12345678, 0, 0, 0);
      check("to_ack_valid", 64'(instr_valid), 64'h1);
      check("to_ack_err", 64'(fetch_err), 64'h0);

      cyc(1, 0, 32'h0, 1, 1, 1);
      check("rst_hold", 64'(instr_valid), 64'h0);

      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom % 60) == 0, ($urandom % 100) < 45, $urandom,
             ($urandom % 3) != 0, 1'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded by reset.
REQ-002 Parameter TIMEOUT, default 255, max cycles imem_req may wait for imem_ack (range 1..255).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port imem_req  output  1  fetch request to instruction memory.
REQ-006 Port imem_addr  output  64  byte address of requested instruction (= pc).
REQ-007 Port imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 Port imem_rdata  input  32  fetched instruction word.
REQ-009 Port instr  output  32  held instruction; bits [31:21] drive the control decoder.
REQ-010 Port instr_valid  output  1  instr and pc are valid for decode.
REQ-011 Port instr_ready  input  1  decode/execute consumes held instruction this cycle.
REQ-012 Port br_taken  input  1  control says branch taken for held instruction.
REQ-013 Port uncond_br  input  1  1: offset from instr[25:0] (B); 0: offset from instr[23:5] (CBZ).
REQ-014 Port pc  output  64  address of held/requested instruction.
REQ-015 Port fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-016 FSM states SHALL be FETCH, HOLD, ERROR.
REQ-017 FETCH: imem_req=1, imem_addr=pc, instr_valid=0; imem_ack=1 at an edge captures imem_rdata into instr, next state HOLD.
REQ-018 imem_ack outside FETCH SHALL be ignored.
REQ-019 Minimum fetch latency: one cycle in FETCH (ack in first FETCH cycle -> instr_valid next cycle).
REQ-020 HOLD: instr_valid=1, imem_req=0; instr and pc stable while instr_ready=0 (unlimited backpressure).
REQ-021 HOLD with instr_ready=1: pc <= next_pc, next state FETCH.
REQ-022 next_pc SHALL be pc+4 if br_taken=0; pc + (sext64(instr[25:0])<<2) if br_taken=1 and uncond_br=1; pc + (sext64(instr[23:5])<<2) if br_taken=1 and uncond_br=0.
REQ-023 All PC arithmetic SHALL be modulo 2^64 (wrap silently at 64'hFFFF_FFFF_FFFF_FFFC+4 -> 0).
REQ-024 br_taken/uncond_br SHALL be sampled only in HOLD with instr_ready=1; X on them elsewhere SHALL not affect state.
REQ-025 Wait counter SHALL clear on entering FETCH, increment each FETCH cycle without ack; reaching TIMEOUT without ack -> state ERROR.
REQ-026 Ack in the same cycle the counter reaches TIMEOUT SHALL win (go HOLD, no error).
REQ-027 ERROR: fetch_err=1, imem_req=0, instr_valid=0; exits only via reset.
REQ-028 imem_req SHALL be 0 in any cycle where reset=1.

Reset
REQ-029 reset=1 at an edge SHALL, from any state, set state=FETCH, pc=RESET_PC, instr=32'h0, wait counter=0, fetch_err=0.
REQ-030 Reset mid-fetch SHALL discard any concurrent imem_ack; first request after reset deasserts uses RESET_PC.
REQ-031 Reset during HOLD SHALL drop instr_valid the next cycle regardless of instr_ready.

Structure
REQ-032 Shared package cpu_pkg SHALL hold fetch_state_t enum (FETCH/HOLD/ERROR), INSTR_W=32, ADDR_W=64, PC_INCR=4.
REQ-033 next_pc computation SHALL be a combinational sub-module pc_next_calc (inputs pc, instr, br_taken, uncond_br; output next_pc).
REQ-034 FSM, counter, pc and instr registers SHALL be single always_ff blocks in instr_fetch.

Verification
REQ-035 Reset, RESET_PC=0, ack after 2 cycles with 32'h91000421 -> imem_addr=0, instr_valid=1 with instr=32'h91000421; instr_ready=1, br_taken=0 -> next imem_addr=0x4.
REQ-036 pc=0x10, instr=32'h17FFFFFE (B, imm26=-2), br_taken=1, uncond_br=1, instr_ready=1 -> next imem_addr=0x08.
REQ-037 pc=0x20, CBZ instr with instr[23:5]=3: br_taken=1, uncond_br=0 -> imem_addr=0x2C; same with br_taken=0 -> 0x24.
REQ-038 HOLD with instr_ready=0 for 5 cycles -> instr, pc, instr_valid unchanged, imem_req=0 throughout.
REQ-039 TIMEOUT=4, no ack -> fetch_err=1 after 4 FETCH cycles, imem_req=0 thereafter; ack on 4th cycle instead -> HOLD, fetch_err=0.
REQ-040 reset asserted in FETCH with imem_ack=1 same cycle -> instr stays 0, instr_valid=0, next request at RESET_PC.
